// File: rtl/m_ex_mem_stage.sv
// m_ex_mem_stage
//   Execute stage of the MIPS 5-stage pipeline plus the EX/MEM pipeline
//   register. A combinational ALU decodes alu_ctrl and works on op_a/op_b.
//   The result, the zero flag, the store data, the destination register and
//   the MEM/WB control bits are registered toward the MEM stage.
//
//   The register update priority is flush > stall > load.
//   - flush writes a bubble: every _q register is cleared.
//   - stall holds every _q register.
//   - load captures new values. Each control bit is gated by valid_in.
//
// Optional feature (macro M_EX_OVF_TRAP_EN):
//   defined   : signed overflow is detected for add and sub. ovf_q is
//               registered, and reg_write_q is suppressed when overflow is set.
//   undefined : there is no overflow logic, and ovf_q is tied to 0.
//
// Ports:
//   clk, rst_n             rising-edge clock, async active-low reset
//   alu_ctrl               ALU operation code
//   op_a, op_b             ALU operands
//   store_data_in          rt value for sw
//   wr_reg_in              destination register
//   valid_in               ID/EX slot holds a real instruction
//   reg_write_in .. branch_in   MEM/WB control bits
//   stall, flush           hold / bubble controls
//   alu_result_q, zero_q   registered ALU result and (result == 0)
//   store_data_q, wr_reg_q registered store data / destination
//   valid_q                registered slot valid
//   reg_write_q .. branch_q     registered controls
//   ovf_q                  registered signed-overflow flag

module m_ex_mem_stage #(
  parameter int N          = 32,
  parameter int N_ALU_CTRL = 4,
  parameter int N_REG_ADDR = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_ALU_CTRL-1:0] alu_ctrl,
  input  logic [N-1:0]          op_a,
  input  logic [N-1:0]          op_b,
  input  logic [N-1:0]          store_data_in,
  input  logic [N_REG_ADDR-1:0] wr_reg_in,
  input  logic                  valid_in,
  input  logic                  reg_write_in,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic                  mem_to_reg_in,
  input  logic                  branch_in,
  input  logic                  stall,
  input  logic                  flush,
  output logic [N-1:0]          alu_result_q,
  output logic                  zero_q,
  output logic [N-1:0]          store_data_q,
  output logic [N_REG_ADDR-1:0] wr_reg_q,
  output logic                  valid_q,
  output logic                  reg_write_q,
  output logic                  mem_read_q,
  output logic                  mem_write_q,
  output logic                  mem_to_reg_q,
  output logic                  branch_q,
  output logic                  ovf_q
);

  localparam logic [N_ALU_CTRL-1:0] ALU_AND = N_ALU_CTRL'(4'b0000);
  localparam logic [N_ALU_CTRL-1:0] ALU_OR  = N_ALU_CTRL'(4'b0001);
  localparam logic [N_ALU_CTRL-1:0] ALU_ADD = N_ALU_CTRL'(4'b0010);
  localparam logic [N_ALU_CTRL-1:0] ALU_SUB = N_ALU_CTRL'(4'b0110);
  localparam logic [N_ALU_CTRL-1:0] ALU_SLT = N_ALU_CTRL'(4'b0111);
  localparam logic [N_ALU_CTRL-1:0] ALU_NOR = N_ALU_CTRL'(4'b1100);

  logic [N-1:0] sum;
  logic [N-1:0] diff;
  logic [N-1:0] result;
  logic         zero;
  logic         slt;
  logic         reg_write_eff;

  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;
  assign slt  = ($signed(op_a) < $signed(op_b));

  always_comb begin
    result = '0;
    case (alu_ctrl)
      ALU_ADD: result = sum;
      ALU_SUB: result = diff;
      ALU_AND: result = op_a & op_b;
      ALU_OR:  result = op_a | op_b;
      ALU_SLT: result = {{(N-1){1'b0}}, slt};
      ALU_NOR: result = ~(op_a | op_b);
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

`ifdef M_EX_OVF_TRAP_EN
  logic ovf_add;
  logic ovf_sub;
  logic overflow;

  // add: the operands have the same sign and the sum's sign differs.
  // sub: the operands differ in sign and the result's sign differs from a.
  assign ovf_add  = (op_a[N-1] == op_b[N-1]) && (sum[N-1]  != op_a[N-1]);
  assign ovf_sub  = (op_a[N-1] != op_b[N-1]) && (diff[N-1] != op_a[N-1]);
  assign overflow = ((alu_ctrl == ALU_ADD) && ovf_add) ||
                    ((alu_ctrl == ALU_SUB) && ovf_sub);

  // An overflowing instruction must not retire its register write.
  assign reg_write_eff = reg_write_in && valid_in && !overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (flush) begin
      ovf_q <= 1'b0;
    end else if (!stall) begin
      ovf_q <= overflow && valid_in;
    end
  end
`else
  assign reg_write_eff = reg_write_in && valid_in;
  assign ovf_q         = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result_q <= '0;
      zero_q       <= 1'b0;
      store_data_q <= '0;
      wr_reg_q     <= '0;
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      branch_q     <= 1'b0;
    end else if (flush) begin
      alu_result_q <= '0;
      zero_q       <= 1'b0;
      store_data_q <= '0;
      wr_reg_q     <= '0;
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      branch_q     <= 1'b0;
    end else if (!stall) begin
      // Data is captured even for a bubble. MEM ignores it because the
      // bubble's controls are masked off.
      alu_result_q <= result;
      zero_q       <= zero;
      store_data_q <= store_data_in;
      wr_reg_q     <= wr_reg_in;
      valid_q      <= valid_in;
      reg_write_q  <= reg_write_eff;
      mem_read_q   <= mem_read_in   && valid_in;
      mem_write_q  <= mem_write_in  && valid_in;
      mem_to_reg_q <= mem_to_reg_in && valid_in;
      branch_q     <= branch_in     && valid_in;
    end
  end

endmodule

// File: tb/tb_m_ex_mem_stage.sv
module tb_m_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a, op_b, store_data_in;
  logic [4:0]  wr_reg_in;
  logic        valid_in, reg_write_in, mem_read_in, mem_write_in;
  logic        mem_to_reg_in, branch_in, stall, flush;
  logic [31:0] alu_result_q, store_data_q;
  logic        zero_q, valid_q, reg_write_q, mem_read_q, mem_write_q;
  logic        mem_to_reg_q, branch_q, ovf_q;
  logic [4:0]  wr_reg_q;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  m_ex_mem_stage dut (
    .clk(clk), .rst_n(rst_n), .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b),
    .store_data_in(store_data_in), .wr_reg_in(wr_reg_in), .valid_in(valid_in),
    .reg_write_in(reg_write_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .mem_to_reg_in(mem_to_reg_in),
    .branch_in(branch_in), .stall(stall), .flush(flush),
    .alu_result_q(alu_result_q), .zero_q(zero_q), .store_data_q(store_data_q),
    .wr_reg_q(wr_reg_q), .valid_q(valid_q), .reg_write_q(reg_write_q),
    .mem_read_q(mem_read_q), .mem_write_q(mem_write_q),
    .mem_to_reg_q(mem_to_reg_q), .branch_q(branch_q), .ovf_q(ovf_q)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".result"}, alu_result_q, 32'h0);
    check({tag, ".zero"},   {31'h0, zero_q}, 32'h0);
    check({tag, ".sdata"},  store_data_q, 32'h0);
    check({tag, ".wr_reg"}, {27'h0, wr_reg_q}, 32'h0);
    check({tag, ".valid"},  {31'h0, valid_q}, 32'h0);
    check({tag, ".ctrls"},  {27'h0, reg_write_q, mem_read_q, mem_write_q,
                             mem_to_reg_q, branch_q}, 32'h0);
    check({tag, ".ovf"},    {31'h0, ovf_q}, 32'h0);
  endtask

  // Apply one instruction, step one edge, and sample 1 time unit later.
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    alu_ctrl = c;
    op_a = a;
    op_b = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; alu_ctrl = 4'h0; op_a = '0; op_b = '0; store_data_in = '0;
    wr_reg_in = '0; valid_in = 1'b0; reg_write_in = 1'b0; mem_read_in = 1'b0;
    mem_write_in = 1'b0; mem_to_reg_in = 1'b0; branch_in = 1'b0;
    stall = 1'b0; flush = 1'b0;
    #12;
    check_all_zero("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset mid-cycle.
    valid_in = 1'b1; reg_write_in = 1'b1; store_data_in = 32'hA5A5_0001; wr_reg_in = 5'd9;
    issue(4'b0010, 32'h1230, 32'h4);
    check("rst.pre_result", alu_result_q, 32'h1234);
    check("rst.pre_valid", {31'h0, valid_q}, 32'h1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_async");
    @(negedge clk);
    rst_n = 1'b1;

    // ALU operations with a=0xF, b=0x3.
    mem_read_in = 1'b1; mem_to_reg_in = 1'b1; branch_in = 1'b1; mem_write_in = 1'b1;
    issue(4'b0010, 32'hF, 32'h3);
    check("add", alu_result_q, 32'h12);
    check("add.zero", {31'h0, zero_q}, 32'h0);
    check("add.sdata", store_data_q, 32'hA5A5_0001);
    check("add.wr_reg", {27'h0, wr_reg_q}, 32'd9);
    check("add.ctrls", {26'h0, valid_q, reg_write_q, mem_read_q, mem_write_q,
                        mem_to_reg_q, branch_q}, 32'h3F);
    mem_read_in = 1'b0; mem_to_reg_in = 1'b0; branch_in = 1'b0; mem_write_in = 1'b0;
    issue(4'b0110, 32'hF, 32'h3);
    check("sub", alu_result_q, 32'h0C);
    check("sub.zero", {31'h0, zero_q}, 32'h0);
    issue(4'b0000, 32'hF, 32'h3);
    check("and", alu_result_q, 32'h03);
    issue(4'b0001, 32'hF, 32'h3);
    check("or", alu_result_q, 32'h0F);
    issue(4'b1100, 32'hF, 32'h3);
    check("nor", alu_result_q, 32'hFFFF_FFF0);
    check("nor.zero", {31'h0, zero_q}, 32'h0);

    // slt, zero and an undefined opcode.
    issue(4'b0111, 32'hFFFF_FFFF, 32'h1);
    check("slt.neg", alu_result_q, 32'h1);
    issue(4'b0111, 32'h1, 32'hFFFF_FFFF);
    check("slt.pos", alu_result_q, 32'h0);
    issue(4'b0110, 32'h55, 32'h55);
    check("sub.eq", alu_result_q, 32'h0);
    check("sub.eq.zero", {31'h0, zero_q}, 32'h1);
    issue(4'b0011, 32'hF, 32'h3);
    check("undef", alu_result_q, 32'h0);
    check("undef.zero", {31'h0, zero_q}, 32'h1);

    // Stall holds, then flush overrides stall.
    issue(4'b0010, 32'hF, 32'h3);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(4'b0110, 32'h100 + i, 32'h1);
      check("stall.result", alu_result_q, 32'h12);
      check("stall.valid", {31'h0, valid_q}, 32'h1);
      check("stall.rw", {31'h0, reg_write_q}, 32'h1);
    end
    flush = 1'b1;
    issue(4'b0010, 32'hF, 32'h3);
    check_all_zero("flush");
    stall = 1'b0; flush = 1'b0;

    // Bubble masking.
    valid_in = 1'b0; mem_write_in = 1'b1; reg_write_in = 1'b1;
    mem_read_in = 1'b1; mem_to_reg_in = 1'b1; branch_in = 1'b1;
    issue(4'b0010, 32'h1, 32'h1);
    check("bubble.valid", {31'h0, valid_q}, 32'h0);
    check("bubble.ctrls", {27'h0, reg_write_q, mem_read_q, mem_write_q,
                           mem_to_reg_q, branch_q}, 32'h0);
    valid_in = 1'b1; mem_write_in = 1'b0; mem_read_in = 1'b0;
    mem_to_reg_in = 1'b0; branch_in = 1'b0;

    // Signed overflow.
    issue(4'b0010, 32'h7FFF_FFFF, 32'h1);
    check("ovf.add.result", alu_result_q, 32'h8000_0000);
`ifdef M_EX_OVF_TRAP_EN
    check("ovf.add.flag", {31'h0, ovf_q}, 32'h1);
    check("ovf.add.rw", {31'h0, reg_write_q}, 32'h0);
`else
    check("ovf.add.flag", {31'h0, ovf_q}, 32'h0);
    check("ovf.add.rw", {31'h0, reg_write_q}, 32'h1);
`endif
    issue(4'b0110, 32'h8000_0000, 32'h1);
    check("ovf.sub.result", alu_result_q, 32'h7FFF_FFFF);
`ifdef M_EX_OVF_TRAP_EN
    check("ovf.sub.flag", {31'h0, ovf_q}, 32'h1);
    check("ovf.sub.rw", {31'h0, reg_write_q}, 32'h0);
`else
    check("ovf.sub.flag", {31'h0, ovf_q}, 32'h0);
    check("ovf.sub.rw", {31'h0, reg_write_q}, 32'h1);
`endif
    issue(4'b0010, 32'h7FFF_FFFE, 32'h1);
    check("noovf.result", alu_result_q, 32'h7FFF_FFFF);
    check("noovf.flag", {31'h0, ovf_q}, 32'h0);
    check("noovf.rw", {31'h0, reg_write_q}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/m_ex_mem_stage.md
Name: m_ex_mem_stage

Overview:
- Execute stage plus EX/MEM pipeline register of the MIPS 5-stage pipeline.
- Consumes the 4-bit ALU control code from the ALU-control decoder, the two ID/EX operands and the downstream control bits.
- Computes the ALU result and zero flag, and registers them with the memory/writeback controls toward the MEM stage.
- Handles stall (hold), flush (bubble insertion) and a valid bit per slot.

Parameters:
- N, 32, datapath width.
- N_ALU_CTRL, 4, ALU control code width.
- N_REG_ADDR, 5, register-file address width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- alu_ctrl  in  N_ALU_CTRL  operation code from ALU-control decoder.
- op_a  in  N  ALU operand A (rs, post-forwarding).
- op_b  in  N  ALU operand B (rt or sign-extended immediate).
- store_data_in  in  N  rt value for sw.
- wr_reg_in  in  N_REG_ADDR  destination register.
- valid_in  in  1  ID/EX slot holds a real instruction.
- reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in, branch_in  in  1 each  control bits.
- stall  in  1  hold EX/MEM contents.
- flush  in  1  replace captured slot with a bubble.
- alu_result_q  out  N  registered ALU result.
- zero_q  out  1  registered (result == 0).
- store_data_q  out  N  registered store data.
- wr_reg_q  out  N_REG_ADDR  registered destination.
- valid_q  out  1  registered slot valid.
- reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q, branch_q  out  1 each  registered controls.
- ovf_q  out  1  registered signed-overflow flag (see Optional Feature).

Behaviour:
- Reset: asynchronous on rst_n low. Every output register clears to 0 (all data, flags, controls, valid_q, ovf_q).
- Combinational ALU, decoded from alu_ctrl:
  - 0010 add: a+b, mod 2^N.
  - 0110 sub: a−b, mod 2^N.
  - 0000 and.
  - 0001 or.
  - 0111 slt: signed a<b gives 1, else 0, zero-extended to N bits.
  - 1100 nor.
  - Any other code gives result 0.
- zero = (result == 0), computed on the N-bit result.
- Latency: 1 cycle from inputs to the _q outputs.
- Update priority at each rising edge: flush > stall > load.
  - flush=1: valid_q, all control _q and ovf_q go to 0. Data _q also clear to 0. Applies even when stall=1.
  - stall=1, flush=0: every _q register holds its value.
  - Otherwise load: data _q capture the computed values; valid_q <= valid_in.
- Control masking on load: each control _q = control_in AND valid_in. A bubble (valid_in=0) can never write memory or the register file. Data still captures, as a don't-care for MEM.
- No internal state other than the pipeline register. Back-to-back loads every cycle are supported.
- rst_n asserted mid-stall or mid-flush clears immediately, without waiting for a clock edge.
- Release of rst_n is synchronous to clk externally; no reset synchronizer inside.

Optional Feature:
- Macro: M_EX_OVF_TRAP_EN.
- Defined:
  - Signed overflow is detected for add (operands same sign, result sign differs) and for sub (operands differ in sign, result sign differs from a).
  - On a valid load, ovf_q <= overflow.
  - reg_write_q is forced to 0 when overflow=1, suppressing the write for an exception handler.
  - ovf_q clears under flush and reset like the other controls.
- Not defined: overflow logic is absent; ovf_q is tied to constant 0. The port is always present so the interface is stable.

Test Plan:
1. Reset: rst_n=0 asynchronously mid-cycle, with prior valid_q=1 and alu_result_q=0x1234 → all outputs read 0 before the next edge.
2. ALU ops, with op_a=0x0000000F, op_b=0x00000003, valid_in=1:
   - alu_ctrl 0010 → alu_result_q=0x12.
   - alu_ctrl 0110 → alu_result_q=0x0C.
   - alu_ctrl 0000 → alu_result_q=0x03.
   - alu_ctrl 0001 → alu_result_q=0x0F.
   - alu_ctrl 1100 → alu_result_q=0xFFFFFFF0.
   - Each result appears one cycle later; zero_q=0.
3. slt/zero:
   - op_a=0xFFFFFFFF, op_b=1, alu_ctrl 0111 → alu_result_q=1.
   - op_a=op_b=0x55, alu_ctrl 0110 → alu_result_q=0, zero_q=1.
4. Stall/flush:
   - Load add result 0x12, then stall=1 for 3 cycles with new inputs → 0x12 held.
   - Then stall=1 with flush=1 → valid_q=0, reg_write_q=0, alu_result_q=0.
5. Bubble masking: valid_in=0, mem_write_in=1, reg_write_in=1 → after the edge, valid_q=0, mem_write_q=0, reg_write_q=0.
6. Overflow, with op_a=0x7FFFFFFF, op_b=1, alu_ctrl 0010, reg_write_in=1:
   - With M_EX_OVF_TRAP_EN: alu_result_q=0x80000000, ovf_q=1, reg_write_q=0.
   - Without the macro: ovf_q=0, reg_write_q=1.
